// File: rtl/cpu_load_pkg.sv
// Shared types and defaults for the program-load / run-control sequencer.
// Command bytes, timeout default and the controller state encoding.
package cpu_load_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_RUN,
    S_HALTED,
    S_STEP
  } state_e;

  localparam logic [7:0] CMD_LOAD_DEF = 8'hA5;
  localparam logic [7:0] CMD_RUN_DEF  = 8'h52;
  localparam logic [7:0] CMD_HALT_DEF = 8'h48;
  localparam logic [7:0] CMD_STEP_DEF = 8'h53;
  localparam int TIMEOUT_DEF = 65535;

  function automatic logic in_load(state_e s);
    return (s == S_CNT_LO) || (s == S_CNT_HI) ||
           (s == S_DATA);
  endfunction

  function automatic logic core_live(state_e s);
    return (s == S_RUN) || (s == S_HALTED) ||
           (s == S_STEP);
  endfunction

endpackage

// File: rtl/load_word_asm.sv
// Little-endian byte-to-word assembler for the instruction RAM loader.
// Pulses word_done the cycle after the fourth byte; clr drops a partial word.
module load_word_asm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        done_q, done_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    done_d = 1'b0;
    if (clr) begin
      idx_d  = 2'd0;
      word_d = 32'd0;
    end else if (byte_en) begin
      word_d = {byte_in, word_q[31:8]};
      idx_d  = idx_q + 2'd1;
      done_d = (idx_q == 2'd3);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= 2'd0;
      word_q <= 32'd0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
      done_q <= done_d;
    end
  end

  assign word      = word_q;
  assign word_done = done_q;

endmodule

// File: rtl/cpu_load_ctrl.sv
// Host byte-stream program loader and run/halt/step sequencer
// driving the core's reset, enable and instruction RAM write port.
module cpu_load_ctrl
  import cpu_load_pkg::*;
#(
  parameter int         ADDR_W   = 12,
  parameter int         TIMEOUT  = TIMEOUT_DEF,
  parameter logic [7:0] CMD_LOAD = CMD_LOAD_DEF,
  parameter logic [7:0] CMD_RUN  = CMD_RUN_DEF,
  parameter logic [7:0] CMD_HALT = CMD_HALT_DEF,
  parameter logic [7:0] CMD_STEP = CMD_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              core_en,
  output logic              busy,
  output logic              running,
  output logic              err,
  output logic [ADDR_W-1:0] words_loaded
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] ONE = 1;
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] wl_q, wl_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              err_q, err_d;
  logic              rdy_q;
  logic              crst_q, cen_q;
  logic              acc, tmo;
  logic              asm_clr, asm_en;

  assign acc = rx_valid && rdy_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    waddr_d = waddr_q;
    wl_d    = wl_q;
    err_d   = err_q;
    timer_d = '0;
    tmo     = 1'b0;
    if (in_load(state_q)) begin
      tmo     = (timer_q == TMO);
      timer_d = acc ? '0 : timer_q + 1'b1;
    end
    case (state_q)
      S_IDLE: if (acc) begin
        if (rx_data == CMD_LOAD)      state_d = S_CNT_LO;
        else if (rx_data == CMD_RUN)  state_d = S_RUN;
        else if (rx_data == CMD_STEP) state_d = S_STEP;
        else if (rx_data != CMD_HALT) err_d = 1'b1;
      end
      S_CNT_LO: if (acc) begin
        count_d = {count_q[ADDR_W-1:8], rx_data};
        state_d = S_CNT_HI;
      end
      S_CNT_HI: if (acc) begin
        count_d = {rx_data[ADDR_W-9:0], count_q[7:0]};
        wl_d    = '0;
        waddr_d = '0;
        state_d = (count_d == '0) ? S_IDLE : S_DATA;
      end
      S_DATA: if (imem_we) begin
        waddr_d = waddr_q + ONE;
        wl_d    = wl_q + ONE;
        if (wl_q + ONE == count_q) state_d = S_IDLE;
      end
      S_RUN: if (acc) begin
        if (rx_data == CMD_HALT)      state_d = S_HALTED;
        else if (rx_data == CMD_LOAD) state_d = S_CNT_LO;
      end
      S_HALTED: if (acc) begin
        if (rx_data == CMD_RUN)       state_d = S_RUN;
        else if (rx_data == CMD_STEP) state_d = S_STEP;
        else if (rx_data == CMD_LOAD) state_d = S_CNT_LO;
      end
      S_STEP:  state_d = S_HALTED;
      default: state_d = S_IDLE;
    endcase
    // A stalled load abandons the partial word but keeps written words.
    if (tmo) begin
      err_d   = 1'b1;
      timer_d = '0;
      state_d = S_IDLE;
    end
  end

  assign asm_clr = (state_q != S_DATA) || tmo;
  assign asm_en  = acc && (state_q == S_DATA);

  load_word_asm u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (asm_clr),
    .byte_en   (asm_en),
    .byte_in   (rx_data),
    .word      (imem_wdata),
    .word_done (imem_we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      waddr_q <= '0;
      wl_q    <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      crst_q  <= 1'b0;
      cen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      waddr_q <= waddr_d;
      wl_q    <= wl_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
      crst_q  <= core_live(state_d);
      cen_q   <= (state_d == S_RUN) || (state_d == S_STEP);
    end
  end

  assign rx_ready     = rdy_q;
  assign imem_waddr   = waddr_q;
  assign core_rst_n   = crst_q;
  assign core_en      = cen_q;
  assign busy         = in_load(state_q);
  assign running      = (state_q == S_RUN);
  assign err          = err_q;
  assign words_loaded = wl_q;

endmodule
